mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage, directly downstream of the execute stage. Registers the execute-stage result bus, aligns and extends load data returned by the synchronous data SRAM, and selects load data or ALU result as the write-back value. Drives the write-back stage and the decode-stage forwarding path. Holds the SRAM read data across downstream stalls so a stalled load never loses its data.

## Interface
- EX_TO_MEM_WD, 76: width of execute-to-memory bus {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- LOAD_WD, 5: load-type bus {lb, lbu, lh, lhu, lw}, MSB first.
- MEM_TO_WB_WD, 70: {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- stall  in  6  pipeline stall vector, 1 = Stop. This stage uses bits [3] and [4].
- ex_to_mem_bus  in  EX_TO_MEM_WD  execute-stage result bus.
- ex_load_bus  in  LOAD_WD  load-type flags of the instruction in execute.
- data_sram_rdata  in  32  SRAM read word. Valid in the first cycle after the request was issued from execute.
- mem_to_wb_bus  out  MEM_TO_WB_WD  to write-back stage.
- mem_to_rf_bus  out  38  forwarding {rf_we, rf_waddr, rf_wdata}.

## Operation
- Pipeline register update, evaluated at each posedge, first match wins:
  - rst: clear the bus register and load register to 0.
  - stall[3]=Stop and stall[4]=NoStop: clear both registers (bubble).
  - stall[3]=NoStop: capture ex_to_mem_bus and ex_load_bus.
  - Otherwise (both Stop): hold.
- Read-data hold FSM, 1-bit state:
  - States: LIVE (reset state) and HELD.
  - LIVE -> HELD when the registers hold (stall[3]=Stop and stall[4]=Stop). In that same cycle, capture data_sram_rdata into rdata_buf.
  - HELD -> HELD while holding; rdata_buf is unchanged.
  - Any register load, bubble, or rst returns the FSM to LIVE.
  - The effective word is data_sram_rdata in LIVE and rdata_buf in HELD.
- Load extension, combinational from the effective word w and offset a = ex_result[1:0] (little-endian):
  - lb/lbu: byte w[8a+7:8a], sign-extended for lb and zero-extended for lbu.
  - lh/lhu: halfword w[31:16] if a[1]=1, else w[15:0]; a[0] is ignored.
  - lw: w as-is; a is ignored.
  - Misalignment raises no exception.
- rf_wdata is the extended load value when sel_rf_res=1 and any load flag is set; otherwise it is ex_result.
- sel_rf_res=1 with no load flag set is treated as a non-load.
- mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata}. mem_to_rf_bus is the low 38 bits of the same fields.
- Stores pass through with rf_we as received (0 from decode). This stage never drives the SRAM.

## Timing
- Register latency: 1 cycle from execute to the outputs. Outputs are combinational from registers, rdata_buf, and data_sram_rdata.
- Reset values: mem_to_wb_bus = 0, mem_to_rf_bus = 0, state = LIVE, rdata_buf = 0.
- For a load entering MEM at edge N, data_sram_rdata is sampled during cycle N→N+1 and rf_wdata is valid in that cycle.
- If stalled at edge N+1, the same value persists from rdata_buf for every further hold cycle, whatever data_sram_rdata does.
- After a bubble, rf_we = 0 and the forwarding bus carries 0.
- rst asserted mid-hold: all state clears at that edge, and the held load is discarded.

## Test plan
- ALU pass-through: bus with ex_result=0x12345678, rf_we=1, waddr=5, sel_rf_res=0 → next cycle rf_wdata=0x12345678, waddr=5, we=1.
- lb sign: ex_result=0x1003, lb, rdata=0x80AABBCC → rf_wdata=0xFFFFFF80. Same case with lbu → 0x00000080.
- lh/lhu: ex_result=0x2002, rdata=0x9ABC1234.
  - lh → 0xFFFF9ABC.
  - lhu → 0x00009ABC.
  - Same case with offset 0 and lh → 0x00001234.
- Stall hold: lw with rdata=0xDEADBEEF, then stall[4:3]=2'b11 for 3 cycles while rdata changes to 0x0 → rf_wdata stays 0xDEADBEEF throughout.
  - After release, the next instruction's value appears.
- Bubble: stall[3]=1, stall[4]=0 at an edge → mem_to_wb_bus=0 next cycle, while the register stays loaded in that cycle.
- Reset mid-hold: rst during the HELD state → next cycle all outputs are 0 and state is LIVE.
  - A following lw with rdata=0x11 → rf_wdata=0x11.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: registers EX results, extends load data, holds SRAM data across stalls
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   stall[5:0]       pipeline stall vector (1 = stop); bit 3 = this stage, bit 4 = write-back
//   ex_to_mem_bus    {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_load_bus      {lb, lbu, lh, lhu, lw}
//   data_sram_rdata  SRAM read word, valid in the cycle after the request left execute
//   mem_to_wb_bus    {pc, rf_we, rf_waddr, rf_wdata} to write-back
//   mem_to_rf_bus    {rf_we, rf_waddr, rf_wdata} forwarding path to decode
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int LOAD_WD      = 5,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_WD-1:0]      ex_load_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus
);

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} state_t;

  logic [EX_TO_MEM_WD-1:0] ex_q;
  logic [LOAD_WD-1:0]      load_q;
  state_t                  state_q, state_d;
  logic [31:0]             rdata_buf, rdata_buf_d;

  logic hold, bubble;
  assign hold   = stall[3] & stall[4];
  assign bubble = stall[3] & ~stall[4];

  // Pipeline registers: bubble clears, run loads, both-stopped holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      load_q <= '0;
    end else if (bubble) begin
      ex_q   <= '0;
      load_q <= '0;
    end else if (!stall[3]) begin
      ex_q   <= ex_to_mem_bus;
      load_q <= ex_load_bus;
    end
  end

  // Read-data hold FSM. The SRAM word is only valid for one cycle, so on the
  // first hold edge it is parked in rdata_buf and served from there until the
  // registers move again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LIVE;
      rdata_buf <= '0;
    end else begin
      state_q   <= state_d;
      rdata_buf <= rdata_buf_d;
    end
  end

  always_comb begin
    state_d     = LIVE;
    rdata_buf_d = rdata_buf;
    if (hold) begin
      state_d = HELD;
      if (state_q == LIVE) rdata_buf_d = data_sram_rdata;
    end
  end

  // Field extraction
  logic [31:0] pc;
  logic        sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  assign pc         = ex_q[75:44];
  assign sel_rf_res = ex_q[38];
  assign rf_we      = ex_q[37];
  assign rf_waddr   = ex_q[36:32];
  assign ex_result  = ex_q[31:0];

  logic ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw;
  assign {ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lw} = load_q;

  // Load alignment / extension
  logic [31:0] eff_word, load_val, rf_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    eff_word = (state_q == HELD) ? rdata_buf : data_sram_rdata;
    case (ex_result[1:0])
      2'd0:    ld_byte = eff_word[7:0];
      2'd1:    ld_byte = eff_word[15:8];
      2'd2:    ld_byte = eff_word[23:16];
      default: ld_byte = eff_word[31:24];
    endcase
    ld_half = ex_result[1] ? eff_word[31:16] : eff_word[15:0];
    if (ld_lb)       load_val = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_lbu) load_val = {24'd0, ld_byte};
    else if (ld_lh)  load_val = {{16{ld_half[15]}}, ld_half};
    else if (ld_lhu) load_val = {16'd0, ld_half};
    else             load_val = eff_word;
    // sel_rf_res without any load flag behaves as a plain ALU op
    rf_wdata = (sel_rf_res && (|load_q)) ? load_val : ex_result;
  end

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

  // Store controls and unrelated stall bits are not consumed here.
  logic unused_sigs;
  assign unused_sigs = ^{stall[5], stall[2:0], ex_q[43:39]};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural reference model
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_load_bus     (ex_load_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the instruction sitting in MEM plus the word it saw
  // on the first stalled edge, if it is currently stalled.
  logic [75:0] m_ex;
  logic [4:0]  m_ld;
  bit          m_holding;
  logic [31:0] m_word;

  function automatic logic [31:0] ref_wdata(input logic [31:0] rdata);
    logic [31:0] w, b, h, res;
    int a;
    res = m_ex[31:0];
    a   = int'(res[1:0]);
    w   = m_holding ? m_word : rdata;
    b   = (w >> (8 * a)) & 32'hFF;
    h   = (w >> (16 * (a / 2))) & 32'hFFFF;
    if (!m_ex[38] || m_ld == 5'd0) return res;
    if (m_ld[4]) return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
    if (m_ld[3]) return b;
    if (m_ld[2]) return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
    if (m_ld[1]) return h;
    return w;
  endfunction

  function automatic logic [69:0] ref_wb(input logic [31:0] rdata);
    return {m_ex[75:44], m_ex[37], m_ex[36:32], ref_wdata(rdata)};
  endfunction

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic sel,
                                        input logic we, input logic [4:0] waddr,
                                        input logic [31:0] res);
    return {pc, 1'b0, 4'b0, sel, we, waddr, res};
  endfunction

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  task automatic drive(input logic [75:0] ex, input logic [4:0] ld, input logic [5:0] st,
                       input logic [31:0] rd, input logic r);
    @(negedge clk);
    ex_to_mem_bus   = ex;
    ex_load_bus     = ld;
    stall           = st;
    data_sram_rdata = rd;
    rst             = r;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_wb"}, mem_to_wb_bus, ref_wb(data_sram_rdata));
    check({tag, "_rf"}, {32'd0, mem_to_rf_bus}, {32'd0, ref_wb(data_sram_rdata)[37:0]});
  endtask

  // Advance across the rising edge and update the model from the driven inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ex = '0; m_ld = '0; m_holding = 0; m_word = '0;
    end else if (stall[3] && !stall[4]) begin
      m_ex = '0; m_ld = '0; m_holding = 0;
    end else if (!stall[3]) begin
      m_ex = ex_to_mem_bus; m_ld = ex_load_bus; m_holding = 0;
    end else if (!m_holding) begin
      m_word = data_sram_rdata; m_holding = 1;
    end
  endtask

  task automatic load_case(input string tag, input logic [31:0] res, input logic [4:0] ld,
                           input logic [31:0] rd, input logic [31:0] exp);
    drive(mk_ex(32'h400, 1'b1, 1'b1, 5'd3, res), ld, 6'd0, $urandom, 1'b0);
    tick();
    drive(mk_ex(32'h404, 1'b0, 1'b0, 5'd0, 32'd0), 5'd0, 6'd0, rd, 1'b0);
    check_model(tag);
    check(tag, {38'd0, mem_to_wb_bus[31:0]}, {38'd0, exp});
    tick();
  endtask

  localparam logic [5:0] ST_HOLD   = 6'b011000;
  localparam logic [5:0] ST_BUBBLE = 6'b001000;
  localparam logic [4:0] LB = 5'b10000, LBU = 5'b01000, LH = 5'b00100, LHU = 5'b00010, LW = 5'b00001;

  initial begin
    m_ex = '0; m_ld = '0; m_holding = 0; m_word = '0;
    ex_to_mem_bus = '0; ex_load_bus = '0; stall = '0; data_sram_rdata = '0; rst = 1'b1;

    // Reset
    drive('1, LW, 6'd0, 32'hFFFF_FFFF, 1'b1);
    tick();
    drive('1, LW, 6'd0, 32'hFFFF_FFFF, 1'b1);
    check("reset_wb", mem_to_wb_bus, 70'd0);
    check("reset_rf", {32'd0, mem_to_rf_bus}, 70'd0);
    tick();

    // ALU pass-through
    drive(mk_ex(32'h100, 1'b0, 1'b1, 5'd5, 32'h12345678), 5'd0, 6'd0, 32'h0, 1'b0);
    tick();
    drive(mk_ex(32'h104, 1'b0, 1'b0, 5'd0, 32'd0), 5'd0, 6'd0, $urandom, 1'b0);
    check("alu_wdata", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h12345678});
    check("alu_waddr_we", {64'd0, mem_to_rf_bus[37:32]}, {64'd0, 1'b1, 5'd5});
    check_model("alu");
    tick();

    // Load extension
    load_case("lb",      32'h1003, LB,  32'h80AABBCC, 32'hFFFFFF80);
    load_case("lbu",     32'h1003, LBU, 32'h80AABBCC, 32'h00000080);
    load_case("lh",      32'h2002, LH,  32'h9ABC1234, 32'hFFFF9ABC);
    load_case("lhu",     32'h2002, LHU, 32'h9ABC1234, 32'h00009ABC);
    load_case("lh_off0", 32'h2000, LH,  32'h9ABC1234, 32'h00001234);
    load_case("lw_misal", 32'h2003, LW, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

    // Stall hold
    drive(mk_ex(32'h200, 1'b1, 1'b1, 5'd7, 32'h3000), LW, 6'd0, 32'h0, 1'b0);
    tick();
    drive(mk_ex(32'h204, 1'b0, 1'b1, 5'd8, 32'hCAFE), 5'd0, ST_HOLD, 32'hDEADBEEF, 1'b0);
    check("hold_live", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hDEADBEEF});
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(mk_ex(32'h204, 1'b0, 1'b1, 5'd8, 32'hCAFE), 5'd0,
            (i < 2) ? ST_HOLD : 6'd0, 32'h0, 1'b0);
      check("hold_buf", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hDEADBEEF});
      check_model("hold");
      tick();
    end
    drive(mk_ex(32'h208, 1'b0, 1'b0, 5'd0, 32'd0), 5'd0, 6'd0, 32'h0, 1'b0);
    check("release", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'hCAFE});
    tick();

    // Bubble
    drive(mk_ex(32'h300, 1'b0, 1'b1, 5'd9, 32'h55), 5'd0, 6'd0, 32'h0, 1'b0);
    tick();
    drive(mk_ex(32'h304, 1'b0, 1'b1, 5'd10, 32'h66), 5'd0, ST_BUBBLE, 32'h0, 1'b0);
    check("bubble_pre", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h55});
    tick();
    drive(mk_ex(32'h308, 1'b0, 1'b0, 5'd0, 32'd0), 5'd0, 6'd0, 32'h1234, 1'b0);
    check("bubble_wb", mem_to_wb_bus, 70'd0);
    check("bubble_rf", {32'd0, mem_to_rf_bus}, 70'd0);
    tick();

    // Reset mid-hold
    drive(mk_ex(32'h500, 1'b1, 1'b1, 5'd4, 32'h4000), LW, 6'd0, 32'h0, 1'b0);
    tick();
    drive('0, 5'd0, ST_HOLD, 32'h77, 1'b0);
    tick();
    drive('0, 5'd0, ST_HOLD, 32'h99, 1'b1);
    check("held_before_rst", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h77});
    tick();
    drive(mk_ex(32'h600, 1'b1, 1'b1, 5'd6, 32'h5000), LW, 6'd0, 32'h22, 1'b0);
    check("rst_hold_wb", mem_to_wb_bus, 70'd0);
    check("rst_hold_rf", {32'd0, mem_to_rf_bus}, 70'd0);
    tick();
    drive('0, 5'd0, 6'd0, 32'h11, 1'b0);
    check("post_rst_lw", {38'd0, mem_to_wb_bus[31:0]}, {38'd0, 32'h11});
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [75:0] ex;
      logic [4:0]  ld;
      logic [5:0]  st;
      int          k;
      ex = {$urandom, $urandom, 12'($urandom)};
      k  = int'($urandom_range(0, 5));
      ld = (k == 5) ? 5'd0 : 5'(1 << k);
      st = 6'($urandom);
      if ($urandom_range(0, 2) == 0) st[4:3] = 2'b00;
      drive(ex, ld, st, $urandom, ($urandom_range(0, 99) == 0));
      check_model("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
